// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage between execute and write-back.
//
// Runs one data-memory transaction per load/store over a req/gnt/rvalid
// handshake. Loads are aligned and extended. Stores are lane-shifted. The
// write-back triple is registered on every clock.
//
// Ports:
//   clk, rst_n                 clock and synchronous active-low reset
//   m_regfile_*_i              write-back target, ALU result or store data, write enable
//   m_data_wr_i / m_data_rd_i  store / load
//   m_data_addr_i              byte address
//   m_data_write_transfer_i    access size (0 byte, 1 half, 2 word)
//   m_is_load_store_i          memory instruction present
//   m_LOAD_op_i                load extension (funct3)
//   data_*                     data-memory bus (req/gnt/rvalid handshake)
//   w_regfile_*_o              registered write-back
//   m_stall_o                  freeze upstream stages while the access is in flight
//   m_misaligned_o             one-cycle pulse for a misaligned access
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  m_regfile_waddr_i,
    input  logic [31:0] m_regfile_rd_i,
    input  logic        m_regfile_wr_i,
    input  logic        m_data_wr_i,
    input  logic        m_data_rd_i,
    input  logic [31:0] m_data_addr_i,
    input  logic [1:0]  m_data_write_transfer_i,
    input  logic        m_is_load_store_i,
    input  logic [2:0]  m_LOAD_op_i,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    input  logic        data_rvalid_i,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_addr_o,
    output logic [31:0] data_wdata_o,
    input  logic [31:0] data_rdata_i,
    output logic [4:0]  w_regfile_waddr_o,
    output logic [31:0] w_regfile_wd_o,
    output logic        w_regfile_wr_o,
    output logic        m_stall_o,
    output logic        m_misaligned_o
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t      state, state_nxt;
    logic [1:0]  off;
    logic        misaligned;
    logic        mem_go;     // aligned memory op that must hit the bus
    logic        done;       // response accepted this cycle
    logic [3:0]  be;
    logic [31:0] rdata_sh;
    logic [31:0] load_data;

    assign off = m_data_addr_i[1:0];

    always_comb begin
        misaligned = 1'b0;
        if (m_is_load_store_i) begin
            if (m_data_write_transfer_i == 2'd1)
                misaligned = off[0];
            else if (m_data_write_transfer_i == 2'd2)
                misaligned = (off != 2'b00);
        end
    end

    assign mem_go = m_is_load_store_i && !misaligned;
    // rvalid only counts in WAIT. A stray response in IDLE/REQ is ignored.
    assign done   = (state == WAIT) && data_rvalid_i;

    // FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM: next state and request
    always_comb begin
        state_nxt  = state;
        data_req_o = 1'b0;
        case (state)
            IDLE: begin
                if (mem_go) begin
                    data_req_o = 1'b1;
                    state_nxt  = data_gnt_i ? WAIT : REQ;
                end
            end
            REQ: begin
                data_req_o = 1'b1;
                if (data_gnt_i) state_nxt = WAIT;
            end
            WAIT: begin
                if (data_rvalid_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case (m_data_write_transfer_i)
            2'd0:    be = 4'b0001 << off;
            2'd1:    be = 4'b0011 << {off[1], 1'b0};
            2'd2:    be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Upstream holds its outputs while stalled, so request fields come
    // straight from the inputs and stay stable for the whole transaction.
    assign data_be_o    = mem_go ? be : 4'b0000;
    assign data_we_o    = mem_go && m_data_wr_i;
    assign data_addr_o  = {m_data_addr_i[31:2], 2'b00};
    assign data_wdata_o = m_regfile_rd_i << {off, 3'b000};
    assign m_stall_o    = mem_go && !done;

    assign rdata_sh = data_rdata_i >> {off, 3'b000};

    always_comb begin
        case (m_LOAD_op_i)
            3'd0:    load_data = {{24{rdata_sh[7]}},  rdata_sh[7:0]};
            3'd1:    load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'd2:    load_data = rdata_sh;
            3'd4:    load_data = {24'b0, rdata_sh[7:0]};
            3'd5:    load_data = {16'b0, rdata_sh[15:0]};
            default: load_data = 32'b0;
        endcase
    end

    // Write-back register. Every cycle that is not a finished op is a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_regfile_waddr_o <= 5'b0;
            w_regfile_wd_o    <= 32'b0;
            w_regfile_wr_o    <= 1'b0;
            m_misaligned_o    <= 1'b0;
        end else begin
            m_misaligned_o    <= misaligned;
            w_regfile_waddr_o <= m_regfile_waddr_i;
            if (!m_is_load_store_i) begin
                w_regfile_wd_o <= m_regfile_rd_i;
                w_regfile_wr_o <= m_regfile_wr_i;
            end else if (mem_go && done && !m_data_wr_i) begin
                w_regfile_wd_o <= load_data;
                w_regfile_wr_o <= m_regfile_wr_i;
            end else begin
                w_regfile_wr_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  m_regfile_waddr_i;
    logic [31:0] m_regfile_rd_i;
    logic        m_regfile_wr_i;
    logic        m_data_wr_i;
    logic        m_data_rd_i;
    logic [31:0] m_data_addr_i;
    logic [1:0]  m_data_write_transfer_i;
    logic        m_is_load_store_i;
    logic [2:0]  m_LOAD_op_i;
    logic        data_req_o;
    logic        data_gnt_i;
    logic        data_rvalid_i;
    logic        data_we_o;
    logic [3:0]  data_be_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic [31:0] data_rdata_i;
    logic [4:0]  w_regfile_waddr_o;
    logic [31:0] w_regfile_wd_o;
    logic        w_regfile_wr_o;
    logic        m_stall_o;
    logic        m_misaligned_o;

    mem_stage dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .m_regfile_waddr_i       (m_regfile_waddr_i),
        .m_regfile_rd_i          (m_regfile_rd_i),
        .m_regfile_wr_i          (m_regfile_wr_i),
        .m_data_wr_i             (m_data_wr_i),
        .m_data_rd_i             (m_data_rd_i),
        .m_data_addr_i           (m_data_addr_i),
        .m_data_write_transfer_i (m_data_write_transfer_i),
        .m_is_load_store_i       (m_is_load_store_i),
        .m_LOAD_op_i             (m_LOAD_op_i),
        .data_req_o              (data_req_o),
        .data_gnt_i              (data_gnt_i),
        .data_rvalid_i           (data_rvalid_i),
        .data_we_o               (data_we_o),
        .data_be_o               (data_be_o),
        .data_addr_o             (data_addr_o),
        .data_wdata_o            (data_wdata_o),
        .data_rdata_i            (data_rdata_i),
        .w_regfile_waddr_o       (w_regfile_waddr_o),
        .w_regfile_wd_o          (w_regfile_wd_o),
        .w_regfile_wr_o          (w_regfile_wr_o),
        .m_stall_o               (m_stall_o),
        .m_misaligned_o          (m_misaligned_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  waddr;
        logic [31:0] wd;
    } wb_t;

    wb_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every write-back the DUT presents must match the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && w_regfile_wr_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_wb", 32'(w_regfile_waddr_o), 32'h0bad);
                end else begin
                    wb_t e;
                    e = exp_q.pop_front();
                    check("wb_waddr", 32'(w_regfile_waddr_o), 32'(e.waddr));
                    check("wb_wd", w_regfile_wd_o, e.wd);
                end
            end
        end
    end

    task automatic clear_inputs();
        m_regfile_waddr_i       = '0;
        m_regfile_rd_i          = '0;
        m_regfile_wr_i          = 1'b0;
        m_data_wr_i             = 1'b0;
        m_data_rd_i             = 1'b0;
        m_data_addr_i           = '0;
        m_data_write_transfer_i = '0;
        m_is_load_store_i       = 1'b0;
        m_LOAD_op_i             = '0;
    endtask

    // One memory transaction. gd = gnt delay cycles, rdd = rvalid delay cycles.
    task automatic mem_op(input logic st, input logic [1:0] tr, input logic [2:0] op,
                          input logic [31:0] addr, input logic [31:0] rdv,
                          input logic [31:0] rdata, input logic [4:0] waddr,
                          input int gd, input int rdd, input logic [3:0] exp_be,
                          input logic [31:0] exp_wdata, input logic [31:0] exp_wd);
        @(negedge clk);
        m_regfile_waddr_i       = waddr;
        m_regfile_rd_i          = rdv;
        m_regfile_wr_i          = !st;
        m_data_wr_i             = st;
        m_data_rd_i             = !st;
        m_data_addr_i           = addr;
        m_data_write_transfer_i = tr;
        m_is_load_store_i       = 1'b1;
        m_LOAD_op_i             = op;
        if (!st) exp_q.push_back('{waddr: waddr, wd: exp_wd});
        for (int c = 0; c <= gd; c++) begin
            data_gnt_i = (c == gd);
            #1;
            check("req_high", 32'(data_req_o), 32'h1);
            check("be", 32'(data_be_o), 32'(exp_be));
            check("wdata", data_wdata_o, exp_wdata);
            check("we", 32'(data_we_o), 32'(st));
            check("addr", data_addr_o, {addr[31:2], 2'b00});
            check("stall_req", 32'(m_stall_o), 32'h1);
            @(negedge clk);
            check("no_wb_while_stalled", 32'(w_regfile_wr_o), 32'h0);
        end
        data_gnt_i = 1'b0;
        for (int c = 0; c <= rdd; c++) begin
            data_rvalid_i = (c == rdd);
            data_rdata_i  = (c == rdd) ? rdata : 32'h0;
            #1;
            check("req_low_wait", 32'(data_req_o), 32'h0);
            check("stall_wait", 32'(m_stall_o), 32'(c != rdd));
            @(negedge clk);
        end
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        clear_inputs();
        #1;
        check("wb_wr_after_done", 32'(w_regfile_wr_o), 32'(!st));
        if (!st) check("wb_wd_after_done", w_regfile_wd_o, exp_wd);
    endtask

    initial begin
        rst_n         = 1'b0;
        data_gnt_i    = 1'b0;
        data_rvalid_i = 1'b0;
        data_rdata_i  = '0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst_wr", 32'(w_regfile_wr_o), 32'h0);
        check("rst_waddr", 32'(w_regfile_waddr_o), 32'h0);
        check("rst_wd", w_regfile_wd_o, 32'h0);
        check("rst_mis", 32'(m_misaligned_o), 32'h0);
        check("rst_req", 32'(data_req_o), 32'h0);
        check("rst_be", 32'(data_be_o), 32'h0);
        check("rst_stall", 32'(m_stall_o), 32'h0);
        rst_n = 1'b1;

        // LW zero-wait
        mem_op(1'b0, 2'd2, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 0, 0, 4'b1111, 32'h0, 32'hDEADBEEF);
        // LB / LBU at byte 3
        mem_op(1'b0, 2'd0, 3'd0, 32'h103, 32'h0, 32'h80112233, 5'd5, 0, 0, 4'b1000, 32'h0, 32'hFFFFFF80);
        mem_op(1'b0, 2'd0, 3'd4, 32'h103, 32'h0, 32'h80112233, 5'd6, 0, 0, 4'b1000, 32'h0, 32'h00000080);
        // SH with 3-cycle gnt delay
        mem_op(1'b1, 2'd1, 3'd0, 32'h102, 32'h0000ABCD, 32'h0, 5'd9, 3, 0, 4'b1100, 32'hABCD0000, 32'h0);
        // LH / LHU at upper half with gnt and rvalid delays
        mem_op(1'b0, 2'd1, 3'd1, 32'h102, 32'h0, 32'h80011234, 5'd10, 1, 2, 4'b1100, 32'h0, 32'hFFFF8001);
        mem_op(1'b0, 2'd1, 3'd5, 32'h102, 32'h0, 32'h80011234, 5'd11, 0, 1, 4'b1100, 32'h0, 32'h00008001);

        // Misaligned LW
        @(negedge clk);
        m_is_load_store_i = 1'b1; m_data_rd_i = 1'b1; m_regfile_wr_i = 1'b1;
        m_regfile_waddr_i = 5'd12; m_data_addr_i = 32'h101;
        m_data_write_transfer_i = 2'd2; m_LOAD_op_i = 3'd2;
        #1;
        check("mis_no_req", 32'(data_req_o), 32'h0);
        check("mis_no_stall", 32'(m_stall_o), 32'h0);
        @(negedge clk);
        clear_inputs();
        check("mis_pulse", 32'(m_misaligned_o), 32'h1);
        check("mis_no_wb", 32'(w_regfile_wr_o), 32'h0);
        @(negedge clk);
        check("mis_pulse_end", 32'(m_misaligned_o), 32'h0);

        // Back-to-back non-memory ops
        m_regfile_waddr_i = 5'd7; m_regfile_rd_i = 32'h5; m_regfile_wr_i = 1'b1;
        exp_q.push_back('{waddr: 5'd7, wd: 32'h5});
        #1;
        check("alu_no_stall", 32'(m_stall_o), 32'h0);
        @(negedge clk);
        check("alu1_wr", 32'(w_regfile_wr_o), 32'h1);
        check("alu1_wd", w_regfile_wd_o, 32'h5);
        m_regfile_waddr_i = 5'd8; m_regfile_rd_i = 32'h1234;
        exp_q.push_back('{waddr: 5'd8, wd: 32'h1234});
        @(negedge clk);
        clear_inputs();
        check("alu2_wr", 32'(w_regfile_wr_o), 32'h1);
        check("alu2_waddr", 32'(w_regfile_waddr_o), 32'h8);
        @(negedge clk);

        // Reset while in WAIT; rvalid arrives after reset
        m_is_load_store_i = 1'b1; m_data_rd_i = 1'b1; m_regfile_wr_i = 1'b1;
        m_regfile_waddr_i = 5'd13; m_data_addr_i = 32'h200;
        m_data_write_transfer_i = 2'd2; m_LOAD_op_i = 3'd2;
        data_gnt_i = 1'b1;
        @(negedge clk);
        data_gnt_i = 1'b0;
        rst_n = 1'b0;
        clear_inputs();
        @(negedge clk);
        #1;
        check("rst_mid_wr", 32'(w_regfile_wr_o), 32'h0);
        check("rst_mid_req", 32'(data_req_o), 32'h0);
        check("rst_mid_be", 32'(data_be_o), 32'h0);
        check("rst_mid_stall", 32'(m_stall_o), 32'h0);
        // Late rvalid with the load still presented: must be treated as IDLE
        rst_n = 1'b1;
        m_is_load_store_i = 1'b1; m_data_rd_i = 1'b1; m_regfile_wr_i = 1'b1;
        m_regfile_waddr_i = 5'd13; m_data_addr_i = 32'h200;
        m_data_write_transfer_i = 2'd2; m_LOAD_op_i = 3'd2;
        data_rvalid_i = 1'b1; data_rdata_i = 32'h11111111;
        #1;
        check("late_rvalid_req", 32'(data_req_o), 32'h1);
        check("late_rvalid_stall", 32'(m_stall_o), 32'h1);
        @(negedge clk);
        check("late_rvalid_no_wb", 32'(w_regfile_wr_o), 32'h0);
        // Finish the reissued access: gnt and rvalid together in REQ, only gnt counts
        data_gnt_i = 1'b1;
        #1;
        check("req_gnt_rvalid_stall", 32'(m_stall_o), 32'h1);
        @(negedge clk);
        data_gnt_i = 1'b0;
        check("req_rvalid_ignored", 32'(w_regfile_wr_o), 32'h0);
        data_rdata_i = 32'hCAFEF00D;
        exp_q.push_back('{waddr: 5'd13, wd: 32'hCAFEF00D});
        @(negedge clk);
        data_rvalid_i = 1'b0;
        clear_inputs();
        check("reissue_wd", w_regfile_wd_o, 32'hCAFEF00D);
        repeat (3) @(negedge clk);

        check("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
